// File: rtl/gamma_stream_coder.sv
// Multi-channel gamma coder: per-channel additive/LFSR generators with warm-up,
// XOR-encoding a valid/ready word stream through a one-deep output register.
module gamma_stream_coder #(
    parameter int unsigned      WIDTH    = 8,
    parameter int unsigned      CHANNELS = 4,
    parameter int unsigned      WARMUP   = 4,
    parameter logic [WIDTH-1:0] POLY     = 8'h1D,
    localparam int unsigned     CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load,
    input  logic [CW-1:0]    key_chan,
    input  logic [WIDTH-1:0] key_seed,
    input  logic [WIDTH-1:0] key_step,
    input  logic             key_mode,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW-1:0]    in_chan,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_chan,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH:0]   out_gamma
);

    localparam int unsigned WCW = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;

    typedef enum logic [1:0] {StIdle, StWarm, StRun} state_e;

    state_e fsm_q, fsm_d;
    logic [WCW-1:0] warm_q;

    logic [WIDTH-1:0] state_q [CHANNELS];
    logic [WIDTH-1:0] state_d [CHANNELS];
    logic [WIDTH-1:0] step_q  [CHANNELS];
    logic [WIDTH-1:0] step_d  [CHANNELS];
    logic             mode_q  [CHANNELS];
    logic             mode_d  [CHANNELS];

    logic [WIDTH-1:0] step_next  [CHANNELS];
    logic [WIDTH:0]   step_gamma [CHANNELS];

    logic             out_valid_q;
    logic [CW-1:0]    out_chan_q;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH:0]   out_gamma_q;

    logic             accept;
    logic             key_chan_ok;
    logic             in_chan_ok;
    logic [WIDTH:0]   sel_gamma;

    assign key_chan_ok = 32'(key_chan) < CHANNELS;
    assign in_chan_ok  = 32'(in_chan) < CHANNELS;

    // Combinational one-step lookahead for every channel; callers pick which to commit.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] lfsr;
        assign sum  = {1'b0, state_q[c]} + {1'b0, step_q[c]};
        assign lfsr = state_q[c][WIDTH-1] ? ((state_q[c] << 1) ^ POLY) : (state_q[c] << 1);
        assign step_next[c]  = mode_q[c] ? lfsr : sum[WIDTH-1:0];
        assign step_gamma[c] = mode_q[c] ? {1'b0, lfsr} : sum;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= StIdle;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM next state
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            StIdle: begin
                if (start) begin
                    fsm_d = (WARMUP > 0) ? StWarm : StRun;
                end
            end
            StWarm: begin
                if (warm_q == WCW'(WARMUP - 1)) begin
                    fsm_d = StRun;
                end
            end
            StRun: begin
                if (stop) begin
                    fsm_d = StIdle;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy     = (fsm_q != StIdle);
        in_ready = (fsm_q == StRun) && (!out_valid_q || out_ready);
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            warm_q <= '0;
        end else if (fsm_q == StWarm) begin
            warm_q <= warm_q + 1'b1;
        end else begin
            warm_q <= '0;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        mode_d  = mode_q;
        if (fsm_q == StIdle && key_load && key_chan_ok) begin
            // An all-zero LFSR state would never leave zero.
            state_d[key_chan] = (key_mode && key_seed == '0) ? WIDTH'(1) : key_seed;
            step_d[key_chan]  = key_step;
            mode_d[key_chan]  = key_mode;
        end
        if (fsm_q == StWarm) begin
            state_d = step_next;
        end
        if (accept && in_chan_ok) begin
            state_d[in_chan] = step_next[in_chan];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= '0;
                step_q[c]  <= '0;
                mode_q[c]  <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
        end
    end

    assign sel_gamma = in_chan_ok ? step_gamma[in_chan] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_data_q  <= '0;
            out_gamma_q <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_chan_q  <= in_chan;
            out_data_q  <= in_data ^ sel_gamma[WIDTH-1:0];
            out_gamma_q <= sel_gamma;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;
    assign out_data  = out_data_q;
    assign out_gamma = out_gamma_q;

endmodule

// File: tb/tb_gamma_stream_coder.sv
// Bench for gamma_stream_coder: cycle model checked every cycle plus hand-computed
// literal expectations for the directed scenarios.
module tb_gamma_stream_coder;

    localparam int unsigned W  = 8;
    localparam int unsigned CH = 4;
    localparam int unsigned WU = 4;
    localparam logic [7:0]  P  = 8'h1D;

    logic       clk, rst;
    logic       key_load, key_mode, start, stop;
    logic [1:0] key_chan, in_chan, out_chan;
    logic [7:0] key_seed, key_step, in_data, out_data;
    logic       busy, in_valid, in_ready, out_valid, out_ready;
    logic [8:0] out_gamma;

    gamma_stream_coder #(
        .WIDTH   (W),
        .CHANNELS(CH),
        .WARMUP  (WU),
        .POLY    (P)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_load (key_load),
        .key_chan (key_chan),
        .key_seed (key_seed),
        .key_step (key_step),
        .key_mode (key_mode),
        .start    (start),
        .stop     (stop),
        .busy     (busy),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_chan  (in_chan),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_chan (out_chan),
        .out_data (out_data),
        .out_gamma(out_gamma)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level step: returns {gamma[8:0], next_state[7:0]}
    function automatic logic [16:0] step_fn(input logic [7:0] s, input logic [7:0] k,
                                            input logic m);
        int sum, nxt;
        if (!m) begin
            sum = int'(s) + int'(k);
            return {9'(sum), 8'(sum % 256)};
        end
        nxt = (int'(s) * 2) % 256;
        if (s >= 8'd128) nxt = nxt ^ int'(P);
        return {1'b0, 8'(nxt), 8'(nxt)};
    endfunction

    // Model state
    logic [7:0] ms [CH];
    logic [7:0] mk [CH];
    logic       mm [CH];
    int         phase;  // 0 idle, 1 warm-up, 2 run
    int         wcnt;
    logic       mv;
    logic [1:0] mchan;
    logic [7:0] mdata;
    logic [8:0] mgam;
    bit         model_on = 0;
    bit         macc;
    logic [16:0] r;

    initial begin
        forever begin
            @(posedge clk);
            macc = (phase == 2) && in_valid && (!mv || out_ready);
            if (rst) begin
                model_on = 1;
                phase = 0; wcnt = 0;
                mv = 0; mchan = 0; mdata = 0; mgam = 0;
                for (int c = 0; c < CH; c++) begin
                    ms[c] = 0; mk[c] = 0; mm[c] = 0;
                end
            end else begin
                if (macc) begin
                    r = step_fn(ms[in_chan], mk[in_chan], mm[in_chan]);
                    ms[in_chan] = r[7:0];
                    mv = 1; mchan = in_chan;
                    mdata = in_data ^ r[15:8];
                    mgam = r[16:8];
                end else if (out_ready) begin
                    mv = 0;
                end
                case (phase)
                    0: begin
                        if (key_load) begin
                            ms[key_chan] = (key_mode && key_seed == 0) ? 8'd1 : key_seed;
                            mk[key_chan] = key_step;
                            mm[key_chan] = key_mode;
                        end
                        if (start) begin
                            phase = (WU > 0) ? 1 : 2;
                            wcnt = 0;
                        end
                    end
                    1: begin
                        for (int c = 0; c < CH; c++) begin
                            r = step_fn(ms[c], mk[c], mm[c]);
                            ms[c] = r[7:0];
                        end
                        wcnt++;
                        if (wcnt == WU) phase = 2;
                    end
                    default: if (stop) phase = 0;
                endcase
            end
        end
    end

    // Every-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (model_on) begin
                check("m_busy", 32'(busy), 32'(phase != 0));
                check("m_in_ready", 32'(in_ready), 32'((phase == 2) && (!mv || out_ready)));
                check("m_out_valid", 32'(out_valid), 32'(mv));
                check("m_out_chan", 32'(out_chan), 32'(mchan));
                check("m_out_data", 32'(out_data), 32'(mdata));
                check("m_out_gamma", 32'(out_gamma), 32'(mgam));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load(input logic [1:0] ch, input logic [7:0] seed, input logic [7:0] stp,
                        input logic m);
        key_load = 1'b1; key_chan = ch; key_seed = seed; key_step = stp; key_mode = m;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Offer one word; returns at the negedge after it was accepted.
    task automatic xfer(input logic [1:0] ch, input logic [7:0] d);
        int n = 0;
        in_valid = 1'b1; in_chan = ch; in_data = d;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) check("accept_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [7:0] d, input logic [8:0] g,
                              input logic [1:0] ch);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_data"}, 32'(out_data), 32'(d));
        check({name, "_gamma"}, 32'(out_gamma), 32'(g));
        check({name, "_chan"}, 32'(out_chan), 32'(ch));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1; key_load = 0; key_chan = 0; key_seed = 0; key_step = 0; key_mode = 0;
        start = 0; stop = 0; in_valid = 0; in_chan = 0; in_data = 0; out_ready = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_gamma", 32'(out_gamma), 32'd0);

        // Additive with warm-up
        load(2'd0, 8'h10, 8'h05, 1'b0);
        go();
        xfer(2'd0, 8'hFF);
        expect_out("add", 8'hD6, 9'h029, 2'd0);

        // Carry out of the adder, back-to-back on one channel
        do_reset();
        load(2'd1, 8'hF2, 8'h03, 1'b0);
        go();
        xfer(2'd1, 8'h00);
        expect_out("carry1", 8'h01, 9'h101, 2'd1);
        xfer(2'd1, 8'h00);
        expect_out("carry2", 8'h04, 9'h004, 2'd1);

        // LFSR, and zero-seed guard
        do_reset();
        load(2'd2, 8'h08, 8'h00, 1'b1);
        go();
        xfer(2'd2, 8'h00);
        expect_out("lfsr", 8'h1D, 9'h01D, 2'd2);
        do_reset();
        load(2'd2, 8'h00, 8'h00, 1'b1);
        go();
        xfer(2'd2, 8'h00);
        expect_out("lfsr_zero", 8'h20, 9'h020, 2'd2);

        // Channel isolation
        do_reset();
        load(2'd0, 8'h10, 8'h05, 1'b0);
        load(2'd3, 8'h80, 8'h00, 1'b1);
        go();
        xfer(2'd0, 8'h00);
        expect_out("iso_a", 8'h29, 9'h029, 2'd0);
        xfer(2'd3, 8'h00);
        expect_out("iso_b", 8'hCD, 9'h0CD, 2'd3);
        xfer(2'd0, 8'h00);
        expect_out("iso_c", 8'h2E, 9'h02E, 2'd0);

        // key_load while running has no effect
        load(2'd0, 8'hAA, 8'h01, 1'b0);
        xfer(2'd0, 8'h00);
        expect_out("key_in_run", 8'h33, 9'h033, 2'd0);

        // stop in the same cycle as an accepted word
        in_valid = 1; in_chan = 2'd0; in_data = 8'h00; stop = 1;
        @(negedge clk);
        in_valid = 0; stop = 0;
        check("stop_busy", 32'(busy), 32'd0);
        expect_out("stop_word", 8'h38, 9'h038, 2'd0);

        // Resume: warm-up runs again on retained state
        go();
        xfer(2'd0, 8'h00);
        expect_out("resume", 8'h51, 9'h051, 2'd0);
        @(negedge clk);

        // Backpressure
        out_ready = 0;
        in_valid = 1; in_chan = 2'd3; in_data = 8'h11;
        @(negedge clk);
        in_data = 8'h22;
        repeat (3) @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        expect_out("bp_hold", 8'h89, 9'h098, 2'd3);
        out_ready = 1;
        @(negedge clk);
        in_data = 8'h33;
        expect_out("bp_w2", 8'h0F, 9'h02D, 2'd3);
        @(negedge clk);
        in_valid = 0;
        expect_out("bp_w3", 8'h69, 9'h05A, 2'd3);
        @(negedge clk);
        check("bp_drain", 32'(out_valid), 32'd0);

        // Reset with a pending output
        out_ready = 0;
        xfer(2'd0, 8'h12);
        check("pend_valid", 32'(out_valid), 32'd1);
        do_reset();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        out_ready = 1;
        go();
        xfer(2'd0, 8'h5A);
        expect_out("post_rst", 8'h5A, 9'h000, 2'd0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gamma_stream_coder.md
Name: gamma_stream_coder

Overview:
Multi-channel, parametrised successor to the single-channel gamma coder. It holds CHANNELS independent gamma generators, each WIDTH bits wide and each in additive or LFSR mode. Every generator runs a warm-up phase before use. In run phase it XOR-encodes a valid/ready data stream, one word per cycle, and routes each word to the generator of the channel it addresses. Sits between the key-setup logic and the stream datapath.

Parameters:
WIDTH, 8, gamma/data width in bits (>=2)
CHANNELS, 4, number of independent generators (>=1); CW = max(1, $clog2(CHANNELS))
WARMUP, 4, discarded generator steps after start (0 allowed)
POLY, 8'h1D, WIDTH-bit Galois feedback polynomial for LFSR mode

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
key_load  in  1  write seed/step/mode into channel key_chan (IDLE only)
key_chan  in  CW  channel to load
key_seed  in  WIDTH  initial state
key_step  in  WIDTH  additive increment (ignored in LFSR mode)
key_mode  in  1  0 = additive, 1 = LFSR
start  in  1  IDLE -> warm-up/run
stop  in  1  RUN -> IDLE
busy  out  1  high in WARM and RUN
in_valid  in  1  input word valid
in_ready  out  1  input accepted this cycle when in_valid & in_ready
in_chan  in  CW  channel for input word
in_data  in  WIDTH  plaintext
out_valid  out  1  output register valid
out_ready  in  1  downstream accept
out_chan  out  CW  channel of output word
out_data  out  WIDTH  in_data ^ gamma
out_gamma  out  WIDTH+1  {carry, gamma} used for this word

Behaviour:
- Reset (rst=1 at edge): FSM=IDLE; all per-channel state/step/mode = 0; warm counter = 0; out_valid=0, out_chan=0, out_data=0, out_gamma=0; busy=0. rst has priority over every other input.
- Step function per channel, sum = {1'b0,s} + {1'b0,k}:
  - additive: s' = sum[WIDTH-1:0]; gamma = sum (WIDTH+1 bits, MSB = carry).
  - LFSR: s' = s[WIDTH-1] ? ((s<<1) ^ POLY) : (s<<1), truncated to WIDTH; gamma = {1'b0, s'}.
- key_load in IDLE: seed, step and mode are written to key_chan. If the mode is LFSR and the seed is 0, the stored seed is 1 (lock-up guard). key_chan >= CHANNELS is ignored. key_load outside IDLE is ignored.
- FSM:
  - IDLE: in_ready=0. start -> WARM if WARMUP>0, else RUN.
  - WARM: every channel steps once per cycle for WARMUP cycles; then -> RUN. start and stop are ignored.
  - RUN: in_ready = !out_valid | out_ready. stop -> IDLE next cycle; a word accepted in that same cycle still completes.
- Accept (RUN, in_valid & in_ready): only channel in_chan steps. On the next edge: out_data = in_data ^ s'; out_gamma = gamma; out_chan = in_chan; out_valid=1. Latency is 1 cycle. Throughput is 1 word/cycle while out_ready=1.
- in_chan >= CHANNELS: word accepted, no state change, gamma = 0, out_data = in_data.
- Back-to-back words on the same channel use the successively advanced state.
- Output hold: while out_valid & !out_ready, out_* stay stable and no new word is accepted. out_valid clears on out_ready unless a new word is accepted in the same cycle.
- In IDLE after stop, a pending output stays until taken. Channel states are retained, so a new start resumes the streams and warm-up applies again.

Test Plan:
- Additive warm-up, WIDTH=8, WARMUP=4: load ch0 seed 0x10 step 0x05, start, send 0xFF on ch0 -> out_data=0xD6, out_gamma=0x029, out_chan=0, 1-cycle latency; busy high from the cycle after start.
- Carry, WARMUP=0: ch1 seed 0xFE step 0x03, send 0x00 then 0x00 on ch1 -> out_gamma 0x101 then 0x004; out_data 0x01 then 0x04.
- LFSR: ch2 mode 1 seed 0x80, WARMUP=0, send 0x00 -> out_data=0x1D, out_gamma=0x01D. Separately, seed 0x00 with mode 1, send 0x00 -> out_data=0x02.
- Channel isolation: ch0 and ch3 loaded, interleave words ch0/ch3/ch0 -> each channel's outputs match its own independent sequence; idle channels do not advance.
- Backpressure: out_ready=0 with in_valid=1 streaming -> exactly one word accepted, in_ready=0 afterwards, out_* stable; raise out_ready -> one word per cycle resumes, none lost or duplicated.
- Reset mid-RUN: assert rst with out_valid=1 -> next cycle out_valid=0, busy=0, IDLE. Restart without key_load -> additive ch0 step 0 gives gamma 0x000 and out_data = in_data.
